// File: rtl/sargantana_icache_ifill_unit_if.sv
// Line-fill channel bundle: cache request/response, L2 request/beat/invalidate.
// Latency: none, wires only.
// Backpressure: request side uses req_ready_o / l2_req_ready_i; beats and invalidations are not stallable.
//
// Signal names keep the unit's port names so waveforms line up with the block.
// slave  : the fill unit's view (drives the *_o signals).
// master : the cache + L2 side (drives the *_i signals).
interface sargantana_icache_ifill_unit_if #(
    parameter int PADDR_W = 40,
    parameter int LINE_W  = 512,
    parameter int BEAT_W  = 128,
    parameter int WAY_W   = 2
);
    localparam int CNT_W = $clog2(LINE_W / BEAT_W);

    // cache -> unit request
    logic               req_valid_i;
    logic [PADDR_W-1:0] req_paddr_i;
    logic [WAY_W-1:0]   req_way_i;
    logic               req_ready_o;
    logic               kill_i;
    // unit -> L2 request
    logic               l2_req_valid_o;
    logic [PADDR_W-1:0] l2_req_paddr_o;
    logic               l2_req_ready_i;
    // L2 -> unit data and invalidations
    logic               l2_beat_valid_i;
    logic [BEAT_W-1:0]  l2_beat_data_i;
    logic               l2_inv_valid_i;
    logic [PADDR_W-1:0] l2_inv_paddr_i;
    // unit -> cache response
    logic               resp_valid_o;
    logic [LINE_W-1:0]  resp_data_o;
    logic [WAY_W-1:0]   resp_way_o;
    logic [CNT_W-1:0]   resp_beat_o;
    logic               resp_inv_valid_o;
    logic [PADDR_W-1:0] resp_inv_paddr_o;
    logic               busy_o;

    modport slave (
        input  req_valid_i, req_paddr_i, req_way_i, kill_i,
        input  l2_req_ready_i, l2_beat_valid_i, l2_beat_data_i,
        input  l2_inv_valid_i, l2_inv_paddr_i,
        output req_ready_o, l2_req_valid_o, l2_req_paddr_o,
        output resp_valid_o, resp_data_o, resp_way_o, resp_beat_o,
        output resp_inv_valid_o, resp_inv_paddr_o, busy_o
    );

    modport master (
        output req_valid_i, req_paddr_i, req_way_i, kill_i,
        output l2_req_ready_i, l2_beat_valid_i, l2_beat_data_i,
        output l2_inv_valid_i, l2_inv_paddr_i,
        input  req_ready_o, l2_req_valid_o, l2_req_paddr_o,
        input  resp_valid_o, resp_data_o, resp_way_o, resp_beat_o,
        input  resp_inv_valid_o, resp_inv_paddr_o, busy_o
    );
endinterface

// File: rtl/sargantana_icache_ifill_unit.sv
// I-cache line-fill unit: one miss -> one L2 request -> N_BEATS beats -> one full-line response.
// Latency: response the cycle after the last beat (one more if an invalidation is going out then); invalidations forwarded 1 cycle after arrival.
// Backpressure: one fill in flight, req_ready_o only in IDLE; L2 request held until l2_req_ready_i; beats and invalidations are never stalled.
//
// Ports: clk_i / rstn_i (synchronous, active low) plus the slave side of
// sargantana_icache_ifill_unit_if carrying the cache request, kill, the L2
// request/beat/invalidate channels and the line/invalidate responses.
// LINE_W/BEAT_W must be a power of two (>= 2) so the beat counter wraps naturally.
module sargantana_icache_ifill_unit #(
    parameter int PADDR_W  = 40,
    parameter int LINE_W   = 512,
    parameter int BEAT_W   = 128,
    parameter int WAY_W    = 2,
    parameter int OFFSET_W = 6
) (
    input  logic clk_i,
    input  logic rstn_i,
    sargantana_icache_ifill_unit_if.slave bus
);
    localparam int N_BEATS = LINE_W / BEAT_W;
    localparam int CNT_W   = $clog2(N_BEATS);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(N_BEATS - 1);
    localparam logic [PADDR_W-1:0] LINE_MASK =
        {{(PADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]         state_q,     state_d;
    logic [PADDR_W-1:0] addr_q,      addr_d;
    logic [WAY_W-1:0]   way_q,       way_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [LINE_W-1:0]  data_q,      data_d;
    logic               inv_vld_q,   inv_vld_d;
    logic [PADDR_W-1:0] inv_paddr_q, inv_paddr_d;

    logic beat_last;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        way_d       = way_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        // Invalidations bypass the FSM entirely; L2 spaces them so a
        // single holding register is enough.
        inv_vld_d   = bus.l2_inv_valid_i;
        inv_paddr_d = bus.l2_inv_valid_i ? bus.l2_inv_paddr_i : inv_paddr_q;
        beat_last   = (cnt_q == LAST_BEAT);

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i && !bus.kill_i) begin
                    addr_d  = bus.req_paddr_i & LINE_MASK;
                    way_d   = bus.req_way_i;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Once L2 has accepted the request its beats will arrive
                // regardless, so a late kill must still swallow them.
                if (bus.l2_req_ready_i) begin
                    state_d = bus.kill_i ? ST_DRAIN : ST_FILL;
                end else if (bus.kill_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (bus.l2_beat_valid_i) begin
                    if (!bus.kill_i) begin
                        for (int b = 0; b < N_BEATS; b++) begin
                            if (cnt_q == CNT_W'(b)) begin
                                data_d[b*BEAT_W +: BEAT_W] = bus.l2_beat_data_i;
                            end
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (beat_last) begin
                        state_d = bus.kill_i ? ST_IDLE : ST_RESP;
                    end else if (bus.kill_i) begin
                        state_d = ST_DRAIN;
                    end
                end else if (bus.kill_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.l2_beat_valid_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (beat_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                // An outgoing invalidation owns this cycle; retry the line
                // next cycle unless the core has killed it meanwhile.
                if (bus.kill_i || !inv_vld_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            way_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            inv_vld_q   <= 1'b0;
            inv_paddr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            inv_vld_q   <= inv_vld_d;
            inv_paddr_q <= inv_paddr_d;
        end
    end

    assign bus.req_ready_o      = (state_q == ST_IDLE);
    assign bus.busy_o           = (state_q != ST_IDLE);
    assign bus.l2_req_valid_o   = (state_q == ST_REQ);
    assign bus.l2_req_paddr_o   = addr_q;
    // Kill masks the pulse in the same cycle so a dead line never escapes.
    assign bus.resp_valid_o     = (state_q == ST_RESP) && !inv_vld_q && !bus.kill_i;
    assign bus.resp_data_o      = data_q;
    assign bus.resp_way_o       = way_q;
    assign bus.resp_beat_o      = cnt_q;
    assign bus.resp_inv_valid_o = inv_vld_q;
    assign bus.resp_inv_paddr_o = inv_paddr_q;
endmodule

// File: tb/tb_sargantana_icache_ifill_unit.sv
module tb_sargantana_icache_ifill_unit;
    localparam int PADDR_W = 40;
    localparam int LINE_W  = 512;
    localparam int BEAT_W  = 128;
    localparam int WAY_W   = 2;
    localparam int N_BEATS = LINE_W / BEAT_W;
    localparam int NO_KILL  = -1;
    localparam int KILL_REQ = -2;
    localparam int KILL_HS  = -3;
    localparam int NO_RST   = -1;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    sargantana_icache_ifill_unit_if #(
        .PADDR_W(PADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .WAY_W(WAY_W)
    ) bus ();

    sargantana_icache_ifill_unit #(
        .PADDR_W(PADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .WAY_W(WAY_W), .OFFSET_W(6)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Reference model state: expected response (one outstanding at most),
    // the cycle it becomes due, expected L2 address and forwarded invalidation.
    int                 pend_set = 0, pend_done = 0, pend_due = 0;
    logic [LINE_W-1:0]  exp_line = '0;
    logic [WAY_W-1:0]   exp_way  = '0;
    logic [PADDR_W-1:0] m_l2_addr = '0;
    logic               m_inv_vld = 1'b0;
    logic [PADDR_W-1:0] m_inv_paddr = '0;
    int                 last_beat_cyc = 0, last_resp_cyc = 0;

    bit                 inv_rand = 1'b0, inv_force = 1'b0;
    logic [PADDR_W-1:0] inv_force_paddr = '0;
    int                 since_inv = 99;

    always @(posedge clk_i) cyc <= cyc + 1;

    // An invalidation seen at an edge is visible for the whole next cycle.
    always @(posedge clk_i) begin
        if (!rstn_i) begin
            m_inv_vld   <= 1'b0;
            m_inv_paddr <= '0;
        end else begin
            m_inv_vld <= bus.l2_inv_valid_i;
            if (bus.l2_inv_valid_i) m_inv_paddr <= bus.l2_inv_paddr_i;
        end
    end

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; invalidations are injected here with L2's 2-cycle spacing.
    task automatic tick();
        logic [63:0] r;
        bit fire;
        fire = inv_force ? (since_inv >= 2)
                         : (inv_rand && since_inv >= 2 && $urandom_range(0, 3) == 0);
        r = {$urandom, $urandom};
        bus.l2_inv_valid_i = fire;
        bus.l2_inv_paddr_i = inv_force ? inv_force_paddr : r[PADDR_W-1:0];
        since_inv = fire ? 1 : since_inv + 1;
        @(posedge clk_i);
        #1;
    endtask

    // The response must appear on the first cycle after the last beat that
    // is not taken by an outgoing invalidation, and at no other time.
    task automatic monitor();
        bit pend, exp_rv;
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                pend   = (pend_set != pend_done);
                exp_rv = pend && (cyc >= pend_due) && !m_inv_vld;
                chk("inv_valid", bus.resp_inv_valid_o, m_inv_vld);
                if (m_inv_vld) chk("inv_paddr", bus.resp_inv_paddr_o, m_inv_paddr);
                chk("resp_valid", bus.resp_valid_o, exp_rv);
                chk("never_both", bus.resp_valid_o & bus.resp_inv_valid_o, 1'b0);
                if (exp_rv) begin
                    chk("resp_data", bus.resp_data_o, exp_line);
                    chk("resp_way", bus.resp_way_o, exp_way);
                    last_resp_cyc = cyc;
                    pend_done++;
                end
                if (bus.l2_req_valid_o) chk("l2_addr", bus.l2_req_paddr_o, m_l2_addr);
            end
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid_i = 1'b0; bus.req_paddr_i = '0; bus.req_way_i = '0;
        bus.kill_i = 1'b0; bus.l2_req_ready_i = 1'b0;
        bus.l2_beat_valid_i = 1'b0; bus.l2_beat_data_i = '0;
    endtask

    task automatic apply_reset(input int cycles);
        rstn_i = 1'b0;
        chk_en = 1'b0;
        clear_inputs();
        repeat (cycles) tick();
        chk("rst_req_ready", bus.req_ready_o, 1'b1);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_l2_valid", bus.l2_req_valid_o, 1'b0);
        chk("rst_l2_paddr", bus.l2_req_paddr_o, '0);
        chk("rst_resp_valid", bus.resp_valid_o, 1'b0);
        chk("rst_resp_data", bus.resp_data_o, '0);
        chk("rst_resp_way", bus.resp_way_o, '0);
        chk("rst_resp_beat", bus.resp_beat_o, '0);
        chk("rst_inv_valid", bus.resp_inv_valid_o, 1'b0);
        chk("rst_inv_paddr", bus.resp_inv_paddr_o, '0);
        rstn_i = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic do_fill(input logic [PADDR_W-1:0] pa, input logic [WAY_W-1:0] way,
                           input int stall, input int gap_min, input int gap_max,
                           input int kill_at, input int rst_at, input bit inv_last,
                           input bit fixed_data);
        logic [LINE_W-1:0] line;
        logic [BEAT_W-1:0] beat;
        logic [3:0]        nib;
        bit                killed;
        int                gap;
        line   = '0;
        killed = 1'b0;
        m_l2_addr = {pa[PADDR_W-1:6], 6'b0};
        bus.req_valid_i = 1'b1; bus.req_paddr_i = pa; bus.req_way_i = way;
        tick();
        bus.req_valid_i = 1'b0; bus.req_paddr_i = '1; bus.req_way_i = ~way;
        chk("req_busy", bus.busy_o, 1'b1);
        chk("req_not_ready", bus.req_ready_o, 1'b0);
        for (int i = 0; i < stall; i++) begin
            chk("l2_req_held", bus.l2_req_valid_o, 1'b1);
            tick();
        end
        chk("l2_req_valid", bus.l2_req_valid_o, 1'b1);
        if (kill_at == KILL_REQ) begin
            bus.kill_i = 1'b1;
            tick();
            bus.kill_i = 1'b0;
            chk("kill_req_l2_drop", bus.l2_req_valid_o, 1'b0);
            chk("kill_req_ready", bus.req_ready_o, 1'b1);
            chk("kill_req_busy", bus.busy_o, 1'b0);
            repeat (2) begin
                tick();
                chk("kill_req_no_l2", bus.l2_req_valid_o, 1'b0);
            end
            return;
        end
        bus.l2_req_ready_i = 1'b1;
        bus.kill_i = (kill_at == KILL_HS);
        killed = (kill_at == KILL_HS);
        tick();
        bus.l2_req_ready_i = 1'b0;
        bus.kill_i = 1'b0;
        chk("l2_req_done", bus.l2_req_valid_o, 1'b0);
        for (int j = 0; j < N_BEATS; j++) begin
            gap = $urandom_range(gap_min, gap_max);
            for (int g = 0; g < gap; g++) begin
                chk("busy_in_gap", bus.busy_o, 1'b1);
                tick();
            end
            if (j == kill_at) begin
                bus.kill_i = 1'b1;
                tick();
                bus.kill_i = 1'b0;
                killed = 1'b1;
            end
            if (j == rst_at) begin
                apply_reset(2);
                return;
            end
            nib  = 4'hA + 4'(j);
            beat = fixed_data ? {32{nib}} : {$urandom, $urandom, $urandom, $urandom};
            line[j*BEAT_W +: BEAT_W] = beat;
            chk("beat_busy", bus.busy_o, 1'b1);
            chk("beat_no_l2req", bus.l2_req_valid_o, 1'b0);
            bus.l2_beat_valid_i = 1'b1;
            bus.l2_beat_data_i  = beat;
            if (j == N_BEATS - 1) begin
                inv_force = inv_last;
                last_beat_cyc = cyc;
                if (!killed) begin
                    exp_line = line;
                    exp_way  = way;
                    pend_due = cyc + 1;
                    pend_set++;
                end
            end
            tick();
            bus.l2_beat_valid_i = 1'b0;
            inv_force = 1'b0;
            chk("beat_count", bus.resp_beat_o, (j + 1) % N_BEATS);
        end
        if (killed) begin
            chk("drain_ready", bus.req_ready_o, 1'b1);
            chk("drain_no_resp", bus.resp_valid_o, 1'b0);
        end else begin
            for (int t = 0; t < 6 && pend_set != pend_done; t++) tick();
            chk("resp_timeout", pend_set - pend_done, 0);
        end
    endtask

    task automatic run_test();
        logic [LINE_W-1:0]  lit_line;
        logic [63:0]        r;
        int                 sel, kat;
        lit_line = {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}};
        clear_inputs();
        bus.l2_inv_valid_i = 1'b0; bus.l2_inv_paddr_i = '0;
        apply_reset(3);
        tick();

        // Basic fill with hand-computed expectations.
        do_fill(40'h80001234, 2'd2, 1, 0, 0, NO_KILL, NO_RST, 1'b0, 1'b1);
        chk("basic_line", bus.resp_data_o, lit_line);
        chk("basic_way", bus.resp_way_o, 2'd2);
        chk("basic_l2_addr", bus.l2_req_paddr_o, 40'h80001200);
        chk("basic_latency", last_resp_cyc - last_beat_cyc, 1);
        tick();

        // Gapped beats.
        do_fill(40'h80002040, 2'd1, 0, 3, 3, NO_KILL, NO_RST, 1'b0, 1'b1);
        chk("gap_line", bus.resp_data_o, lit_line);
        tick();

        // A stray beat while idle must be ignored.
        bus.l2_beat_valid_i = 1'b1; bus.l2_beat_data_i = '1;
        tick();
        bus.l2_beat_valid_i = 1'b0;
        chk("stray_beat_cnt", bus.resp_beat_o, '0);
        chk("stray_beat_busy", bus.busy_o, 1'b0);
        chk("stray_beat_data", bus.resp_data_o, lit_line);

        // Kill after beat 1, kill in REQ with L2 stalled, kill on handshake.
        do_fill(40'h80003000, 2'd3, 0, 0, 1, 2, NO_RST, 1'b0, 1'b0);
        do_fill(40'h80003100, 2'd0, 3, 0, 0, KILL_REQ, NO_RST, 1'b0, 1'b0);
        do_fill(40'h80003200, 2'd1, 1, 0, 1, KILL_HS, NO_RST, 1'b0, 1'b0);
        tick();

        // Invalidation on the same cycle as the last beat.
        since_inv = 99;
        inv_force_paddr = 40'h80004000;
        do_fill(40'h80005000, 2'd3, 0, 0, 0, NO_KILL, NO_RST, 1'b1, 1'b1);
        chk("coll_latency", last_resp_cyc - last_beat_cyc, 2);
        chk("coll_inv_paddr", bus.resp_inv_paddr_o, 40'h80004000);
        chk("coll_way", bus.resp_way_o, 2'd3);

        // Reset after beats 0..2, then a clean fill.
        do_fill(40'h80006000, 2'd2, 0, 0, 0, NO_KILL, 3, 1'b0, 1'b1);
        tick();
        do_fill(40'h800070FF, 2'd1, 2, 0, 0, NO_KILL, NO_RST, 1'b0, 1'b1);
        chk("post_rst_line", bus.resp_data_o, lit_line);
        chk("post_rst_l2_addr", bus.l2_req_paddr_o, 40'h800070C0);

        // Randomized traffic with background invalidations.
        inv_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            kat = (sel == 0) ? KILL_REQ : (sel == 1) ? KILL_HS :
                  (sel == 2) ? $urandom_range(0, N_BEATS - 1) : NO_KILL;
            r = {$urandom, $urandom};
            inv_force_paddr = r[PADDR_W-1:0];
            r = {$urandom, $urandom};
            do_fill(r[PADDR_W-1:0], WAY_W'($urandom_range(0, 3)), $urandom_range(0, 3),
                    0, 2, kat, NO_RST, ($urandom_range(0, 3) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        inv_rand = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        fork
            monitor();
            run_test();
            begin
                #1000000;
                n_fail++;
                $display("FAIL watchdog: simulation time limit reached");
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sargantana_icache_ifill_unit.md
Name: sargantana_icache_ifill_unit

Overview:
- Sits directly downstream of the instruction cache's miss path, between the cache's ifill request port and the L2/upper memory.
- Accepts one line-fill request (physical line address plus victim way) and issues it to L2.
- Gathers the in-order data beats from L2 into one full cache line and returns it to the cache as a single-cycle fill response.
- Also registers L2 invalidations and forwards them, and drains beats for fills that the core kills.

Parameters:
PADDR_W, 40, physical address width
LINE_W, 512, cache-line width in bits
BEAT_W, 128, L2 beat width; LINE_W/BEAT_W = N_BEATS, must be a power of 2 and at least 2
WAY_W, 2, victim-way index width
OFFSET_W, 6, line offset bits forced to zero on the L2 address

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
req_valid_i  in  1  fill request from the cache
req_paddr_i  in  PADDR_W  line address of the miss
req_way_i  in  WAY_W  victim way
req_ready_o  out  1  unit can accept a request (state IDLE)
kill_i  in  1  core kill; the pending fill is discarded
l2_req_valid_o  out  1  request to L2
l2_req_paddr_o  out  PADDR_W  line-aligned address
l2_req_ready_i  in  1  L2 accepts the request
l2_beat_valid_i  in  1  data beat valid
l2_beat_data_i  in  BEAT_W  beat data, in order, lowest beat first
l2_inv_valid_i  in  1  invalidation from L2
l2_inv_paddr_i  in  PADDR_W  invalidation address
resp_valid_o  out  1  filled line valid (1-cycle pulse)
resp_data_o  out  LINE_W  assembled line
resp_way_o  out  WAY_W  way latched with the request
resp_beat_o  out  log2(N_BEATS)  count of beats received so far
resp_inv_valid_o  out  1  forwarded invalidation
resp_inv_paddr_o  out  PADDR_W  forwarded invalidation address
busy_o  out  1  state is not IDLE

Behaviour:
- Reset (rstn_i=0 at a clock edge):
  - State goes to IDLE.
  - All valid outputs, busy_o, the beat counter, data, way, address and invalidation registers are cleared to 0.
  - Reset applied mid-fill abandons the fill; no response is produced.
- FSM states: IDLE, REQ, FILL, RESP, DRAIN.
- IDLE:
  - req_ready_o=1.
  - req_valid_i && !kill_i: latch the address as {req_paddr_i[PADDR_W-1:OFFSET_W], OFFSET_W zeros}, latch req_way_i, clear the counter, go to REQ.
  - req_valid_i && kill_i in the same cycle: the request is ignored.
- REQ:
  - l2_req_valid_o=1 with the latched address.
  - l2_req_valid_o stays high and the address stays stable until l2_req_ready_i.
  - On handshake go to FILL.
  - kill_i in REQ before the handshake: return to IDLE and never issue the request.
  - kill_i in the handshake cycle: go to DRAIN.
- FILL:
  - Each l2_beat_valid_i writes l2_beat_data_i into slice [cnt*BEAT_W +: BEAT_W] and increments cnt.
  - On the beat with cnt==N_BEATS-1, go to RESP and wrap cnt to 0.
  - kill_i in FILL: go to DRAIN, keeping the count.
- DRAIN:
  - Beats are consumed and counted, data is not written.
  - On the last beat go to IDLE.
  - resp_valid_o is never asserted for a killed fill.
- RESP:
  - resp_valid_o=1 for exactly one cycle with the full line and the latched way, then go to IDLE.
  - Latency: resp_valid_o rises the cycle after the last beat.
  - kill_i during RESP: the response is suppressed and the unit returns to IDLE. The cache also masks its own response.
- Invalidations:
  - l2_inv_valid_i is registered and appears on resp_inv_valid_o/resp_inv_paddr_o the next cycle as a 1-cycle pulse, in any state.
  - If the registered invalidation and a RESP pulse coincide, the invalidation goes out and the line response is held in RESP one more cycle.
  - resp_valid_o and resp_inv_valid_o are never high together.
  - A new invalidation arriving while one is held overwrites it (L2 guarantees spacing of at least 2 cycles).
- Beats outside FILL/DRAIN are protocol errors and are ignored (assertion in the bench).
- resp_beat_o reflects cnt.
- resp_data_o holds its last value outside RESP.

Test Plan:
- Basic fill, N_BEATS=4:
  - Stimulus: req paddr=0x80001234, way=2; l2_req_ready_i on 2nd cycle; beats 0xA..,0xB..,0xC..,0xD.. on consecutive cycles.
  - Response: l2_req_paddr_o=0x80001200; resp_valid_o one cycle after beat 3; resp_data_o={D,C,B,A}; resp_way_o=2.
- Gapped beats:
  - Stimulus: insert 3 idle cycles between beats.
  - Response: same line; a single resp pulse; busy_o high throughout.
- Kill in FILL:
  - Stimulus: kill after beat 1.
  - Response: remaining 2 beats drained, no resp_valid_o, req_ready_o=1 the cycle after the last beat.
- Kill in REQ with L2 stalled:
  - Response: l2_req_valid_o drops, no beats expected, return to IDLE.
- Invalidation/response collision:
  - Stimulus: inv paddr=0x80004000 the same cycle as the last beat.
  - Response: resp_inv_valid_o the next cycle, resp_valid_o one cycle later, never both high together.
- Reset mid-fill:
  - Stimulus: rstn_i low after beat 2.
  - Response: all outputs 0; a new request completes correctly.
